// File: rtl/sha_round_sequencer.sv
// rtl/sha_round_sequencer.sv - SHA round sequencer: start qualification, round stepping, done/ack handshake
// Optional macro SEQ_START_LATCH_EN adds sticky per-channel start pending bits.
module sha_round_sequencer #(
    parameter int NUM_START  = 2,
    parameter int ROUNDS     = 64,
    parameter int CNT_W      = 6,
    parameter int START_MODE = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_START-1:0] start,
    input  logic                 clear,
    input  logic                 stall,
    input  logic                 done_ack,
    output logic                 enable,
    output logic [CNT_W-1:0]     round_idx,
    output logic                 first_round,
    output logic                 last_round,
    output logic                 done,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROUNDS - 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     idx_next;
    logic [NUM_START-1:0] req;
    logic                 go;

`ifdef SEQ_START_LATCH_EN
    logic [NUM_START-1:0] pending;

    // Requests accumulate outside RUN so channels may assert in different cycles.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            pending <= '0;
        end else if (state != RUN) begin
            pending <= (state_next == RUN) ? '0 : (pending | start);
        end
    end

    assign req = pending | start;
`else
    assign req = start;
`endif

    assign go = (START_MODE == 0) ? &req : |req;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            round_idx <= '0;
        end else begin
            state     <= state_next;
            round_idx <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = round_idx;
        if (clear) begin
            state_next = IDLE;
            idx_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state_next = RUN;
                        idx_next   = '0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (round_idx == LAST_IDX) begin
                            state_next = DONE;
                            idx_next   = '0;
                        end else begin
                            idx_next = round_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (done_ack) begin
                        state_next = go ? RUN : IDLE;
                        idx_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        enable      = (state == RUN);
        done        = (state == DONE);
        busy        = (state == RUN) || (state == DONE);
        first_round = (state == RUN) && (round_idx == '0);
        last_round  = (state == RUN) && (round_idx == LAST_IDX);
    end

endmodule

// File: tb/tb_sha_round_sequencer.sv
// tb/tb_sha_round_sequencer.sv - randomized and directed bench for sha_round_sequencer (AND and OR modes)
module tb_sha_round_sequencer;

    localparam int NS = 2;
    localparam int R  = 64;
    localparam int CW = 6;

    logic          clock = 1'b0;
    logic          reset;
    logic [NS-1:0] start;
    logic          clear;
    logic          stall;
    logic          done_ack;

    logic          enable_o [2];
    logic [CW-1:0] idx_o    [2];
    logic          first_o  [2];
    logic          last_o   [2];
    logic          done_o   [2];
    logic          busy_o   [2];

    int            n_checks = 0;
    int            n_pass   = 0;

    int            ph   [2];
    int            rd   [2];
    logic [NS-1:0] pend [2];

    always #5 clock = ~clock;

    sha_round_sequencer #(.NUM_START(NS), .ROUNDS(R), .CNT_W(CW), .START_MODE(0)) dut_and (
        .clock(clock), .reset(reset), .start(start), .clear(clear), .stall(stall), .done_ack(done_ack),
        .enable(enable_o[0]), .round_idx(idx_o[0]), .first_round(first_o[0]), .last_round(last_o[0]),
        .done(done_o[0]), .busy(busy_o[0])
    );

    sha_round_sequencer #(.NUM_START(NS), .ROUNDS(R), .CNT_W(CW), .START_MODE(1)) dut_or (
        .clock(clock), .reset(reset), .start(start), .clear(clear), .stall(stall), .done_ack(done_ack),
        .enable(enable_o[1]), .round_idx(idx_o[1]), .first_round(first_o[1]), .last_round(last_o[1]),
        .done(done_o[1]), .busy(busy_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model phases: 0 idle, 1 running block, 2 waiting for acknowledge.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            logic [NS-1:0] rq;
            logic          g;
            rq = start;
`ifdef SEQ_START_LATCH_EN
            rq = start | pend[m];
`endif
            g = (m == 0) ? (rq == {NS{1'b1}}) : (rq != '0);
            if (reset || clear) begin
                ph[m] = 0; rd[m] = 0; pend[m] = '0;
            end else if (ph[m] == 1) begin
                if (!stall) begin
                    if (rd[m] == R - 1) begin ph[m] = 2; rd[m] = 0; end
                    else rd[m] = rd[m] + 1;
                end
            end else if (g && (ph[m] == 0 || done_ack)) begin
                ph[m] = 1; rd[m] = 0; pend[m] = '0;
            end else begin
                if (ph[m] == 2 && done_ack) ph[m] = 0;
                pend[m] = pend[m] | start;
            end
        end
    endtask

    function automatic logic [31:0] exp_vec(input int m);
        logic en;
        en = (ph[m] == 1);
        return {21'd0, en, CW'(rd[m]), en && rd[m] == 0, en && rd[m] == R - 1, ph[m] == 2, ph[m] != 0};
    endfunction

    function automatic logic [31:0] got_vec(input int m);
        return {21'd0, enable_o[m], idx_o[m], first_o[m], last_o[m], done_o[m], busy_o[m]};
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check("model_and", got_vec(0), exp_vec(0));
        check("model_or", got_vec(1), exp_vec(1));
    endtask

    initial begin
        int n;
        int last_at;
        reset = 1'b1; start = '0; clear = 1'b0; stall = 1'b0; done_ack = 1'b0;
        foreach (pend[i]) begin ph[i] = 0; rd[i] = 0; pend[i] = '0; end
        cycle(); cycle();
        check("reset_busy", 32'(busy_o[0]), 32'd0);
        reset = 1'b0;
        cycle();

        // Full block: latency to last_round and done.
        start = 2'b11;
        cycle();
        start = '0;
        check("t1_enable", 32'(enable_o[0]), 32'd1);
        check("t1_first", 32'(first_o[0]), 32'd1);
        n = 0; last_at = -1;
        while (!done_o[0] && n < 200) begin
            if (last_o[0]) last_at = n;
            cycle();
            n++;
        end
        check("t1_last_at", 32'(last_at), 32'd63);
        check("t1_done_lat", 32'(n), 32'd64);
        check("t1_done_en", 32'(enable_o[0]), 32'd0);

        done_ack = 1'b1;
        cycle();
        done_ack = 1'b0;
        check("t5_ack_idle", 32'(busy_o[0]), 32'd0);

        // Stall for three cycles at round 10.
        start = 2'b11;
        cycle();
        start = '0;
        n = 0;
        while (idx_o[0] != 6'd10 && n < 200) begin cycle(); n++; end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(); n++;
            check("t2_hold", 32'(idx_o[0]), 32'd10);
        end
        stall = 1'b0;
        while (!done_o[0] && n < 300) begin cycle(); n++; end
        check("t2_done_lat", 32'(n), 32'd67);

        // Back-to-back restart from DONE.
        done_ack = 1'b1; start = 2'b11;
        cycle();
        done_ack = 1'b0; start = '0;
        check("t5_b2b_en", 32'(enable_o[0]), 32'd1);
        check("t5_b2b_idx", 32'(idx_o[0]), 32'd0);

        // Abort at round 20 while stalled.
        n = 0;
        while (idx_o[0] != 6'd20 && n < 200) begin cycle(); n++; end
        stall = 1'b1; clear = 1'b1;
        cycle();
        stall = 1'b0; clear = 1'b0;
        check("t4_busy", 32'(busy_o[0]), 32'd0);
        check("t4_idx", 32'(idx_o[0]), 32'd0);
        n = 0;
        for (int i = 0; i < 80; i++) begin cycle(); if (done_o[0]) n++; end
        check("t4_no_done", 32'(n), 32'd0);

        // Qualification modes.
        start = 2'b01;
        cycle();
        start = '0;
        check("t3_and_idle", 32'(enable_o[0]), 32'd0);
        check("t3_or_run", 32'(enable_o[1]), 32'd1);
        clear = 1'b1; cycle(); clear = 1'b0;

        // Split requests on different cycles.
        start = 2'b01; cycle();
        start = '0; cycle(); cycle();
        start = 2'b10; cycle();
        start = '0;
`ifdef SEQ_START_LATCH_EN
        check("t6_latch", 32'(enable_o[0]), 32'd1);
`else
        check("t6_latch", 32'(enable_o[0]), 32'd0);
`endif
        clear = 1'b1; cycle(); clear = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            start    = NS'($urandom);
            stall    = ($urandom % 4) == 0;
            clear    = ($urandom % 60) == 0;
            done_ack = ($urandom % 3) == 0;
            reset    = ($urandom % 250) == 0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha_round_sequencer.md
Name: sha_round_sequencer

Overview:
- Parametrised successor to the SHA-256 message-enable latch.
- Qualifies N start requests, raises a sticky enable, and steps a round index 0..ROUNDS-1, with stall support.
- Reports completion through a done/ack handshake and supports synchronous abort.
- Sits between the message loader and the compression datapath; its round_idx addresses the K-constant ROM and W schedule.

Parameters:
- NUM_START, 2, number of start request inputs to qualify.
- ROUNDS, 64, rounds per block; legal range 2..256.
- CNT_W, 6, round index width; must satisfy 2**CNT_W >= ROUNDS.
- START_MODE, 0, qualification mode: 0 = all start bits high (AND); 1 = any start bit high (OR).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high; clock clock.
- start  in  NUM_START  start request bits.
- clear  in  1  synchronous abort to IDLE.
- stall  in  1  holds round_idx while in RUN.
- done_ack  in  1  acknowledges done.
- enable  out  1  high while in RUN (datapath enable).
- round_idx  out  CNT_W  current round number.
- first_round  out  1  enable && round_idx==0.
- last_round  out  1  enable && round_idx==ROUNDS-1.
- done  out  1  high in DONE state.
- busy  out  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. All outputs registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset values: state=IDLE, enable=0, round_idx=0, done=0, busy=0, first_round=0, last_round=0.
- Priority, highest first: reset, clear, then normal transitions.
- go is the qualified start:
  - START_MODE=0: AND of all start bits.
  - START_MODE=1: OR of all start bits.
  - Only go is evaluated from start; individual bits are never registered (unless the optional feature is compiled in).
- IDLE:
  - go sampled high in cycle T -> RUN in T+1 with enable=1, round_idx=0, first_round=1.
  - go low -> stay in IDLE.
- RUN:
  - Each cycle with stall=0: round_idx increments.
  - stall=1: round_idx and all outputs hold.
  - round_idx==ROUNDS-1 with stall=0 -> DONE next cycle, with enable=0, done=1, round_idx=0.
  - Exactly ROUNDS non-stalled enable cycles per block.
  - start is ignored in RUN.
- DONE:
  - done held until done_ack=1.
  - done_ack=1 with go=0 -> IDLE next cycle.
  - done_ack=1 with go=1 in the same cycle -> RUN next cycle, round_idx=0 (back-to-back, no idle gap).
  - start without done_ack is ignored.
- done_ack outside DONE has no effect.
- clear=1 in any state -> IDLE next cycle, round_idx=0, enable=0, done=0.
  - clear overrides stall, go and done_ack in the same cycle.
- Reset mid-RUN: same as clear; no partial completion is reported.
- round_idx never exceeds ROUNDS-1; no wrap inside RUN.

Optional Feature:
- Macro: SEQ_START_LATCH_EN.
- Defined:
  - Each start bit sets a per-channel sticky pending bit in IDLE and DONE.
  - go is evaluated on (pending | start), so requests may arrive in different cycles.
  - Pending bits clear on entry to RUN, on clear, and on reset.
  - Start bits seen during RUN are dropped.
- Undefined:
  - No pending storage; in AND mode all start bits must be high in the same cycle, as in the original enable latch.

Test Plan:
1. Reset, then start=2'b11 at T -> enable=1, round_idx=0, first_round=1 at T+1; last_round at T+64; done=1 at T+65 with enable=0.
2. Stall: stall=1 for 3 cycles at round_idx=10 -> round_idx stays 10 for 3 cycles; done arrives 3 cycles later than in scenario 1.
3. Qualification:
   - START_MODE=0 with start=2'b01 -> remains IDLE.
   - START_MODE=1 with start=2'b01 -> RUN next cycle.
4. Abort: clear=1 at round_idx=20 with stall=1 -> IDLE next cycle, round_idx=0, done never asserts.
5. Handshake:
   - done_ack=1 and start=2'b11 in the same cycle in DONE -> RUN next cycle, round_idx=0.
   - done_ack alone -> IDLE next cycle, busy=0.
6. With SEQ_START_LATCH_EN: start=2'b01 at T, start=2'b10 at T+3 -> RUN at T+4; without the macro -> stays IDLE.
